uart8n1_rx: RTL and testbench
=============================

// Module: uart8n1_rx
// PURPOSE
//  Receive side of the 8N1 UART link; counterpart of the 8N1 transmitter on the same divp divisor.
//  Oversamples rxd with the system clock and recovers 8-bit frames (start, 8 data LSB first, 1 stop).
//  Pushes good bytes into an internal FIFO read by the SDIO-side logic via rxen/dat.
//  Flags framing errors and FIFO overruns as single-cycle pulses.
// PARAMETERS
//  FIFO_DEPTH  16  receive FIFO entries; power of 2, >=2
//  AW          4   FIFO address width, log2(FIFO_DEPTH)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active high
//  rxd        in   1   serial input, asynchronous, idle high
//  divp       in   16  bit period minus 1, in clk cycles (same meaning as TX divp); divp>=3
//  rxen       in   1   pop: consume the FIFO head this cycle (ignored when rxempty)
//  dat        out  8   FIFO head byte, valid while rxempty=0
//  rxfull     out  1   FIFO holds FIFO_DEPTH bytes
//  rxempty    out  1   FIFO holds 0 bytes
//  frame_err  out  1   1-clk pulse: stop bit sampled low
//  overrun    out  1   1-clk pulse: good byte dropped because FIFO full
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state IDLE, counters 0, FIFO emptied; rxempty=1, rxfull=0,
//   frame_err=0, overrun=0, synchronizer regs=1; dat=8'h00. Reset mid-frame abandons the frame.
//  Input sync: rxd through 2 flops (reset to 1); FSM uses synchronized rxs only.
//  Bit period = divp+1 clks; divcnt counts 0..divp; mid-bit point = divcnt==divp>>1.
//  FSM:
//   IDLE: on rxs==0 -> START, divcnt=0.
//   START: at mid-bit, rxs==1 -> IDLE (glitch, no flag); rxs==0 -> DATA, divcnt=0, bitidx=0.
//    From here every sample is taken when divcnt==divp (one full period after previous mid-bit).
//   DATA: at sample, shift rxs into bit[bitidx] (LSB first); after bitidx 7 -> STOP.
//   STOP: at sample: rxs==1 -> push byte, -> IDLE immediately (no wait for bit end);
//    rxs==0 -> frame_err pulse, byte discarded, -> BREAK.
//   BREAK: wait for rxs==1, then -> IDLE (no new start detected while line held low).
//  Push: in the stop-sample cycle; if FIFO full and no pop that cycle -> byte dropped,
//   overrun pulse, FIFO contents unchanged. Full with simultaneous pop -> push accepted.
//  FIFO: first-word-fall-through; dat = head, registered; updated the clk after push into
//   empty FIFO (rxempty falls same edge). Pop with rxen=1 & rxempty=0 advances head next edge.
//  Simultaneous push+pop: count unchanged; on empty FIFO pop is ignored, push accepted.
//  Pointers AW bits wrap naturally; count AW+1 bits; rxfull = count==FIFO_DEPTH.
//  divp changed mid-frame: undefined frame, FSM must still return to IDLE; no lock-up.
//  Latency: rxempty falls <= 2 + (divp>>1) + 9*(divp+1) + 2 clks after rxd falling edge.
// TESTING
//  divp=15, send 0xA5 8N1 -> one push, dat=8'hA5, rxempty 1->0, frame_err=0, overrun=0.
//  divp=15, 1-clk low glitch on idle rxd -> no push, FSM back to IDLE, no flags.
//  divp=15, send 0x3C with stop bit low, hold rxd low 40 clks, then 0x55 -> frame_err one
//   pulse, 0x3C discarded, 0x55 received correctly.
//  divp=7, 17 back-to-back bytes 0x00..0x10, rxen=0 -> first 16 stored, rxfull=1,
//   overrun pulses once, pops return 0x00..0x0F in order, then rxempty=1.
//  FIFO full, rxen=1 in the stop-sample cycle of byte 0x99 -> no overrun, 0x99 is last popped.
//  rst=1 during DATA bit 4 of 0xF0 -> outputs at reset values, next clean 0x81 received ok.

Source files
------------

// File: rtl/uart8n1_rx.sv
// uart8n1_rx: 8N1 UART receiver with a first-word-fall-through receive FIFO.
// Latency: rxempty falls 3 + (divp>>1) + 9*(divp+1) clks after the first posedge that sees rxd low.
// Backpressure: none on the line side; a good byte arriving while the FIFO is full (and not popped) is dropped with an overrun pulse.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   rxd        asynchronous serial input, idle high
//   divp       bit period minus one, in clk cycles (>= 3)
//   rxen       pop request for the FIFO head (ignored while rxempty)
//   dat        FIFO head byte, valid while rxempty is low
//   rxfull     FIFO holds FIFO_DEPTH bytes
//   rxempty    FIFO holds no bytes
//   frame_err  one-clk pulse when the stop bit is sampled low
//   overrun    one-clk pulse when a good byte is dropped on a full FIFO

module uart8n1_rx #(
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] divp,
  input  logic        rxen,
  output logic [7:0]  dat,
  output logic        rxfull,
  output logic        rxempty,
  output logic        frame_err,
  output logic        overrun
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // ---------------------------------------------------------------
  // Input synchronizer (reset to the idle line level)
  // ---------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // ---------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] divcnt_q, divcnt_d;
  logic [2:0]  bitidx_q, bitidx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        frame_err_q, frame_err_d;
  logic        push;
  logic [15:0] half;

  assign half = {1'b0, divp[15:1]};

  // Sample points use >= rather than == so that a divp reduced mid-frame
  // below the current count still terminates the bit instead of waiting
  // for a 16-bit wrap.
  always_comb begin
    state_d     = state_q;
    divcnt_d    = divcnt_q;
    bitidx_d    = bitidx_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d  = ST_START;
          divcnt_d = 16'd0;
        end
      end

      ST_START: begin
        if (divcnt_q >= half) begin
          divcnt_d = 16'd0;
          bitidx_d = 3'd0;
          // A start bit that is high again at mid-bit was a glitch.
          state_d  = rxs ? ST_IDLE : ST_DATA;
        end else begin
          divcnt_d = divcnt_q + 16'd1;
        end
      end

      ST_DATA: begin
        if (divcnt_q >= divp) begin
          divcnt_d          = 16'd0;
          shreg_d[bitidx_q] = rxs;
          if (bitidx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bitidx_d = bitidx_q + 3'd1;
          end
        end else begin
          divcnt_d = divcnt_q + 16'd1;
        end
      end

      ST_STOP: begin
        if (divcnt_q >= divp) begin
          divcnt_d = 16'd0;
          if (rxs) begin
            // Return to IDLE at mid stop bit so the next start edge is
            // caught even with some baud mismatch.
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          divcnt_d = divcnt_q + 16'd1;
        end
      end

      ST_BREAK: begin
        // A held-low line is not a new start bit; wait for idle first.
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      divcnt_q    <= 16'd0;
      bitidx_q    <= 3'd0;
      shreg_q     <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      divcnt_q    <= divcnt_d;
      bitidx_q    <= bitidx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------
  // Receive FIFO, first-word-fall-through with a registered head
  // ---------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    dat_q, dat_d;
  logic          overrun_q, overrun_d;
  logic          fifo_empty, fifo_full;
  logic          pop_ok, push_ok;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop_ok     = rxen & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok    = push & (~fifo_full | pop_ok);
  assign rd_nxt     = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dat_d     = dat_q;
    overrun_d = push & fifo_full & ~pop_ok;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_nxt;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // The head register must track what the head will be after this edge:
    // the incoming byte when it becomes the only entry, otherwise the next
    // stored entry on a pop. On a full push+pop the write lands on the slot
    // being vacated, so mem[rd_nxt] is still the old second entry.
    if (push_ok && (fifo_empty || (pop_ok && count_q == (AW+1)'(1)))) begin
      dat_d = shreg_q;
    end else if (pop_ok && count_q > (AW+1)'(1)) begin
      dat_d = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr_q] <= shreg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dat_q     <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dat_q     <= dat_d;
      overrun_q <= overrun_d;
    end
  end

  assign dat     = dat_q;
  assign rxfull  = fifo_full;
  assign rxempty = fifo_empty;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart8n1_rx.sv
// tb_uart8n1_rx: directed serial frames into uart8n1_rx, scoreboard on the FIFO output.
// Latency: n/a (bench).
// Backpressure: the monitor pops whenever popping is enabled or a pop is scheduled for a given edge.

module tb_uart8n1_rx;

  logic        clk;
  logic        rst;
  logic        rxd;
  logic [15:0] divp;
  logic        rxen;
  logic [7:0]  dat;
  logic        rxfull;
  logic        rxempty;
  logic        frame_err;
  logic        overrun;

  uart8n1_rx #(.FIFO_DEPTH(16), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .divp      (divp),
    .rxen      (rxen),
    .dat       (dat),
    .rxfull    (rxfull),
    .rxempty   (rxempty),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         nvec;
  int         nmis;
  int         fe_cnt;
  int         ov_cnt;
  bit         pop_en;
  int         pop_at_cyc;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: counts flag pulses and pops/compares the FIFO head.
  task automatic monitor();
    logic       pop;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      pop = !rst && (rxempty === 1'b0) && (pop_en || (cyc + 1 == pop_at_cyc));
      if (pop) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nmis++;
          $display("FAIL pop_unexpected: got %0h expected no data", dat);
        end else begin
          e = exp_q.pop_front();
          if (dat !== e) begin
            nmis++;
            $display("FAIL pop_data: got %0h expected %0h", dat, e);
          end
        end
      end
      rxen = pop;
    end
  endtask

  // Each bit is held for divp+1 cycles; tasks start and end on a negedge.
  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (int'(divp) + 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopv, input bit pop_stop);
    // Start edge set just before posedge E0; stop bit is sampled at
    // E(3 + divp/2 + 9*(divp+1)), i.e. cyc == now + 4 + divp/2 + 9*(divp+1).
    if (pop_stop) pop_at_cyc = cyc + 4 + (int'(divp) >> 1) + 9 * (int'(divp) + 1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stopv);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && rxempty === 1'b1) break;
      @(negedge clk);
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_rxempty"}, rxempty, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    nvec = 0; nmis = 0; fe_cnt = 0; ov_cnt = 0;
    pop_en = 1'b1; pop_at_cyc = -1;
    rst = 1'b1; rxd = 1'b1; divp = 16'd15; rxen = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rxempty", rxempty, 1'b1);
    check("rst_rxfull", rxfull, 1'b0);
    check("rst_dat", dat, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte 0xA5 at divp=15
    check("a5_pre_rxempty", rxempty, 1'b1);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b0);
    wait_drain("a5");
    check("a5_fe", fe_cnt, 0);
    check("a5_ov", ov_cnt, 0);

    // One-clock glitch on an idle line
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rxempty", rxempty, 1'b1);
    check("glitch_fe", fe_cnt, 0);

    // Framing error on 0x3C, line held low, then 0x55
    send_byte(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("fe_pulse", fe_cnt, 1);
    check("fe_rxempty", rxempty, 1'b1);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, 1'b0);
    wait_drain("b55");
    check("fe_ov", ov_cnt, 0);
    check("fe_pulse_after", fe_cnt, 1);

    // 17 back-to-back bytes at divp=7 with no pops
    divp = 16'd7;
    pop_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      b = 8'(i);
      if (i < 16) exp_q.push_back(b);
      send_byte(b, 1'b1, 1'b0);
    end
    repeat (4) @(negedge clk);
    check("ovr_rxfull", rxfull, 1'b1);
    check("ovr_pulse", ov_cnt, 1);
    pop_en = 1'b1;
    wait_drain("ovr");
    check("ovr_rxfull_after", rxfull, 1'b0);

    // Full FIFO, pop exactly in the stop-sample cycle of 0x99
    pop_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = 8'h20 + 8'(i);
      exp_q.push_back(b);
      send_byte(b, 1'b1, 1'b0);
    end
    repeat (4) @(negedge clk);
    check("sim_rxfull", rxfull, 1'b1);
    exp_q.push_back(8'h99);
    send_byte(8'h99, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("sim_ov", ov_cnt, 1);
    check("sim_rxfull_after", rxfull, 1'b1);
    check("sim_one_popped", exp_q.size(), 16);
    pop_en = 1'b1;
    wait_drain("sim");

    // Reset during data bit 4 of 0xF0, then a clean 0x81
    divp = 16'd15;
    repeat (4) @(negedge clk);
    b = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rxd = b[4];
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst_rxempty", rxempty, 1'b1);
    check("mrst_rxfull", rxfull, 1'b0);
    check("mrst_dat", dat, 8'h00);
    check("mrst_frame_err", frame_err, 1'b0);
    check("mrst_overrun", overrun, 1'b0);
    rst = 1'b0;
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1, 1'b0);
    wait_drain("b81");
    check("final_fe", fe_cnt, 1);
    check("final_ov", ov_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
